// File: rtl/instr_load_mem_pkg.sv
// Shared definitions for the instruction load/fetch memory: FSM states,
// the default NOP word and the index-width helper.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/instr_load_mem_if.sv
// Load/fetch bus of instr_load_mem. load_csum exists only when
// LOAD_CHECKSUM_EN is defined.
interface instr_load_mem_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int PC_W   = 32
);
  import instr_mem_pkg::*;

  localparam int CNT_W = idx_width(DEPTH) + 1;

  logic              LoadInstructions;
  logic              load_valid;
  logic [DATA_W-1:0] Instruction;
  logic              load_ready;
  logic              fetch_en;
  logic [PC_W-1:0]   fetch_pc;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic [CNT_W-1:0]  instr_count;
  logic              load_full;
  logic              load_overflow;
  logic [1:0]        state_out;
`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] load_csum;
`endif

  modport master (
    output LoadInstructions, load_valid, Instruction, fetch_en, fetch_pc,
    input  load_ready, instr_out, instr_valid, instr_count, load_full,
           load_overflow, state_out
`ifdef LOAD_CHECKSUM_EN
    , input load_csum
`endif
  );

  modport slave (
    input  LoadInstructions, load_valid, Instruction, fetch_en, fetch_pc,
    output load_ready, instr_out, instr_valid, instr_count, load_full,
           load_overflow, state_out
`ifdef LOAD_CHECKSUM_EN
    , output load_csum
`endif
  );

endinterface

// File: rtl/instr_load_mem_ram.sv
// Instruction storage: one write port, one registered read port.
// The array is deliberately left without reset.
module instr_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IW     = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_load_mem.sv
// Instruction store with load controller (IDLE/LOAD/RUN) and registered fetch.
// Define LOAD_CHECKSUM_EN to add the running XOR checksum load_csum.
module instr_load_mem
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input logic              clk,
  input logic              Reset,
  instr_load_mem_if.slave  bus
);

  localparam int IW = idx_width(DEPTH);
  localparam int CW = IW + 1;

  state_t            state, next_state;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              valid_q;
  logic              hit_q;
  logic              full, ready, accept, enter_load, fetch_go, hit;
  logic [IW-1:0]     fetch_idx;
  logic [DATA_W-1:0] rd_data;

  assign full       = (count == CW'(DEPTH));
  assign ready      = (state == LOAD) && !full;
  assign accept     = bus.load_valid && ready;
  assign enter_load = (state != LOAD) && bus.LoadInstructions;
  assign fetch_go   = (state == RUN) && bus.fetch_en;
  assign fetch_idx  = bus.fetch_pc[IW+1:2];
  assign hit        = ({1'b0, fetch_idx} < count) && (bus.fetch_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.LoadInstructions)  next_state = LOAD;
      LOAD:    if (!bus.LoadInstructions) next_state = RUN;
      RUN:     if (bus.LoadInstructions)  next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // count doubles as the write pointer: both clear together and step together
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (enter_load) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) count <= count + 1'b1;
      if ((state == LOAD) && bus.load_valid && full) overflow <= 1'b1;
    end
  end

  // hit_q only moves on a fetch, so instr_out holds between requests
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= fetch_go;
      if (fetch_go) hit_q <= hit;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)          csum <= '0;
    else if (enter_load) csum <= '0;
    else if (accept)     csum <= csum ^ bus.Instruction;
  end

  assign bus.load_csum = csum;
`endif

  instr_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (count[IW-1:0]),
    .wr_data (bus.Instruction),
    .rd_en   (fetch_go),
    .rd_addr (fetch_idx),
    .rd_data (rd_data)
  );

  assign bus.load_ready    = ready;
  assign bus.instr_out     = hit_q ? rd_data : NOP_WORD;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_count   = count;
  assign bus.load_full     = full;
  assign bus.load_overflow = overflow;
  assign bus.state_out     = state;

endmodule

// File: tb/tb_instr_load_mem.sv
// Scoreboard bench for instr_load_mem with DEPTH=64 and DEPTH=4 instances;
// checksum checks run only when LOAD_CHECKSUM_EN is defined.
module tb_instr_load_mem;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] q64[$];
  logic [31:0] q4[$];
  logic [31:0] prog [13];

  instr_load_mem_if #(.DATA_W(32), .DEPTH(64), .PC_W(32)) bus64 ();
  instr_load_mem_if #(.DATA_W(32), .DEPTH(4),  .PC_W(32)) bus4 ();

  instr_load_mem #(.DATA_W(32), .DEPTH(64), .PC_W(32)) u64 (
    .clk(clk), .Reset(rst_n), .bus(bus64)
  );
  instr_load_mem #(.DATA_W(32), .DEPTH(4), .PC_W(32)) u4 (
    .clk(clk), .Reset(rst_n), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] data,
                                input logic load);
    bus64.load_valid       = valid;
    bus64.Instruction      = data;
    bus64.LoadInstructions = load;
    @(negedge clk);
  endtask

  task automatic fetch64(input logic [31:0] pc, input logic [31:0] expected);
    bus64.fetch_en = 1'b1;
    bus64.fetch_pc = pc;
    q64.push_back(expected);
    @(negedge clk);
  endtask

  task automatic fetch4(input logic [31:0] pc, input logic [31:0] expected);
    bus4.fetch_en = 1'b1;
    bus4.fetch_pc = pc;
    q4.push_back(expected);
    @(negedge clk);
  endtask

  // Monitors pop one expected word for every instr_valid pulse
  always @(negedge clk) begin
    if (bus64.instr_valid) begin
      if (q64.size() == 0)
        check_output("fetch64_unexpected_valid", 32'd1, 32'd0);
      else
        check_output("fetch64", bus64.instr_out, q64.pop_front());
    end
    if (bus4.instr_valid) begin
      if (q4.size() == 0)
        check_output("fetch4_unexpected_valid", 32'd1, 32'd0);
      else
        check_output("fetch4", bus4.instr_out, q4.pop_front());
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    prog = '{32'h20010010, 32'h20020005, 32'h00221820, 32'h00622022,
             32'h00832824, 32'h00A43025, 32'h00C53826, 32'h00E64027,
             32'h0107482A, 32'hAC090004, 32'h8C0A0004, 32'h014B6020,
             32'h016C682A};
    bus64.LoadInstructions = 0; bus64.load_valid = 0; bus64.Instruction = '0;
    bus64.fetch_en = 0;         bus64.fetch_pc = '0;
    bus4.LoadInstructions = 0;  bus4.load_valid = 0;  bus4.Instruction = '0;
    bus4.fetch_en = 0;          bus4.fetch_pc = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_state", 32'(bus64.state_out), 32'd0);
    check_output("rst_valid", 32'(bus64.instr_valid), 32'd0);
    check_output("rst_instr", bus64.instr_out, NOP);
    check_output("rst_count", 32'(bus64.instr_count), 32'd0);
    check_output("rst_ready", 32'(bus64.load_ready), 32'd0);
    check_output("rst_ovf", 32'(bus64.load_overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: 13 words; LoadInstructions drops with the last word
    bus64.LoadInstructions = 1'b1;
    @(negedge clk);
    check_output("load_state", 32'(bus64.state_out), 32'd1);
    check_output("load_ready", 32'(bus64.load_ready), 32'd1);
    for (int i = 0; i < 13; i++) apply_stimulus(1'b1, prog[i], i != 12);
    bus64.load_valid = 1'b0;
    check_output("s1_count", 32'(bus64.instr_count), 32'd13);
    check_output("s1_state", 32'(bus64.state_out), 32'd2);
    check_output("s1_full", 32'(bus64.load_full), 32'd0);
    fetch64(32'd0, prog[0]);
    fetch64(32'd48, prog[12]);
    bus64.fetch_en = 1'b0;
    @(negedge clk);

    // Scenario 2: unloaded, misaligned and aliased addresses
    fetch64(32'd52, NOP);
    fetch64(32'd2, NOP);
    fetch64(32'd260, prog[1]);
    bus64.fetch_en = 1'b0;
    @(negedge clk);
    check_output("s2_valid_low", 32'(bus64.instr_valid), 32'd0);

    // Scenario 5: reload with a fetch on the same edge, then gapped valid
    bus64.LoadInstructions = 1'b1;
    fetch64(32'd4, prog[1]);
    check_output("s5_count_clr", 32'(bus64.instr_count), 32'd0);
    for (int i = 0; i < 8; i++) apply_stimulus(i % 2 == 0, 32'hA000_0000 + i, 1'b1);
    bus64.fetch_en = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    check_output("s5_count", 32'(bus64.instr_count), 32'd4);
    check_output("s5_hold", bus64.instr_out, prog[1]);
    fetch64(32'd16, NOP);
    fetch64(32'd0, 32'hA000_0000);
    fetch64(32'd4, 32'hA000_0002);
    fetch64(32'd8, 32'hA000_0004);
    fetch64(32'd12, 32'hA000_0006);
    bus64.fetch_en = 1'b0;
    @(negedge clk);

    // Scenario 3: DEPTH=4 overflow
    bus4.LoadInstructions = 1'b1;
    @(negedge clk);
    check_output("s3_ready", 32'(bus4.load_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus4.load_valid  = 1'b1;
      bus4.Instruction = 32'hC0DE_0000 + i;
      @(negedge clk);
    end
    check_output("s3_count", 32'(bus4.instr_count), 32'd4);
    check_output("s3_full", 32'(bus4.load_full), 32'd1);
    check_output("s3_ready_full", 32'(bus4.load_ready), 32'd0);
    check_output("s3_ovf", 32'(bus4.load_overflow), 32'd1);
    bus4.load_valid = 1'b0;
    bus4.LoadInstructions = 1'b0;
    @(negedge clk);
    fetch4(32'd12, 32'hC0DE_0003);
    fetch4(32'd16, 32'hC0DE_0000);
    bus4.fetch_en = 1'b0;
    bus4.LoadInstructions = 1'b1;
    @(negedge clk);
    check_output("s3_ovf_clr", 32'(bus4.load_overflow), 32'd0);
    check_output("s3_count_clr", 32'(bus4.instr_count), 32'd0);
    check_output("s3_ready_again", 32'(bus4.load_ready), 32'd1);
    bus4.LoadInstructions = 1'b0;
    @(negedge clk);

    // Scenario 4: reset in the middle of a load
    bus64.LoadInstructions = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, prog[i], 1'b1);
    check_output("s4_count3", 32'(bus64.instr_count), 32'd3);
    rst_n = 1'b0;
    bus64.load_valid = 1'b0;
    bus64.LoadInstructions = 1'b0;
    #1;
    check_output("s4_state", 32'(bus64.state_out), 32'd0);
    check_output("s4_count", 32'(bus64.instr_count), 32'd0);
    check_output("s4_ready", 32'(bus64.load_ready), 32'd0);
    check_output("s4_instr", bus64.instr_out, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    check_output("s4_run", 32'(bus64.state_out), 32'd2);
    fetch64(32'd0, NOP);
    bus64.fetch_en = 1'b0;
    @(negedge clk);

`ifdef LOAD_CHECKSUM_EN
    // Scenario 6: checksum accumulates, holds in RUN, clears on reload
    apply_stimulus(1'b0, 32'h0, 1'b1);
    apply_stimulus(1'b1, 32'hFFFF_0000, 1'b1);
    apply_stimulus(1'b1, 32'h0000_FFFF, 1'b0);
    bus64.load_valid = 1'b0;
    check_output("csum", bus64.load_csum, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    check_output("csum_hold", bus64.load_csum, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    check_output("csum_clr", bus64.load_csum, 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check_output("pending64", 32'(q64.size()), 32'd0);
    check_output("pending4", 32'(q4.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
